// File: rtl/paddle_input_pkg.sv
// Shared pong definitions: paddle FSM state encoding and default debounce timing.
package paddle_input_pkg;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned CNT_W_DEF           = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/paddle_input_if.sv
// Button/tick inputs and paddle command outputs between gameplay and paddle_input.
interface paddle_input_if;
  logic btn_up;
  logic btn_down;
  logic tick;
  logic input_up;
  logic input_down;
  logic step;

  modport master (output btn_up, btn_down, tick, input input_up, input_down, step);
  modport slave  (input btn_up, btn_down, tick, output input_up, input_down, step);
endinterface

// File: rtl/paddle_input_btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce counter.
module btn_debounce
  import paddle_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_i,
  output logic db_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  // Any cycle where the synchronized level matches the accepted state restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) db_d = ~db_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  assign db_o = db_q;
endmodule

// File: rtl/paddle_input.sv
// Debounces the two paddle buttons and arbitrates them into up/down command levels
// plus a per-tick step pulse.
module paddle_input
  import paddle_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input logic           clk,
  input logic           clr_n,
  paddle_input_if.slave bus
);
  logic          up_db, down_db;
  paddle_state_e state_q, state_d;
  logic          step_q, step_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clk   (clk),
    .clr_n (clr_n),
    .btn_i (bus.btn_up),
    .db_o  (up_db)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
    .clk   (clk),
    .clr_n (clr_n),
    .btn_i (bus.btn_down),
    .db_o  (down_db)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Both buttons held cancels motion; leaving UP/DOWN always passes through IDLE.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    if (bus.tick) begin
      step_d = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (up_db && !down_db)      state_d = UP;
          else if (down_db && !up_db) state_d = DOWN;
        end
        UP:      if (!up_db || down_db) state_d = IDLE;
        DOWN:    if (!down_db || up_db) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.input_up   = (state_q == UP);
  assign bus.input_down = (state_q == DOWN);
  assign bus.step       = step_q;
endmodule

// File: doc/paddle_input.md
PADDLE_INPUT -- requirements
Module: paddle_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable clk samples (10 ms at 50 MHz) required to accept a button level change.
REQ-002 Parameter CNT_W, default 20, is the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  master clock (50 MHz); the only clock in the block.
REQ-004 clr_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_up  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-006 btn_down  input  1  raw asynchronous pushbutton, 1 = pressed.
REQ-007 tick  input  1  single-cycle movement-step strobe in the clk domain, the gameplay paddle update rate.
REQ-008 input_up  output  1  registered paddle-up command level to gameplay.
REQ-009 input_down  output  1  registered paddle-down command level to gameplay.
REQ-010 step  output  1  one-cycle pulse, asserted on the clk after any tick while input_up or input_down is asserted.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each button SHALL have its own debounce counter and debounced-state flop (up_db, down_db).
REQ-013 While the synchronized level equals the debounced state, that button's counter SHALL hold at 0.
REQ-014 While the synchronized level differs, the counter SHALL increment each clk. When it reaches DEBOUNCE_CYCLES-1 and the level still differs, the debounced state SHALL toggle on the next edge and the counter SHALL clear.
REQ-015 A level mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles SHALL clear the counter and leave the debounced state unchanged.
REQ-016 Latency from a clean pin edge to the debounced-state change SHALL be exactly 2 + DEBOUNCE_CYCLES clk cycles.
REQ-017 The arbitration FSM SHALL have three states: IDLE, UP, DOWN.
REQ-018 The FSM SHALL evaluate transitions only on cycles where tick = 1; it SHALL hold state otherwise.
REQ-019 IDLE SHALL go to UP if up_db=1 and down_db=0, and SHALL go to DOWN if down_db=1 and up_db=0; otherwise it stays in IDLE.
REQ-020 UP SHALL go to IDLE if up_db=0 or down_db=1; DOWN SHALL go to IDLE if down_db=0 or up_db=1. Both pressed means no motion, and no direct UP<->DOWN transition is allowed.
REQ-021 input_up SHALL be 1 only in state UP and input_down SHALL be 1 only in state DOWN; the two SHALL never be 1 simultaneously.
REQ-022 step SHALL be 1 for exactly one clk after a tick cycle in which the FSM was in UP or DOWN before the edge.
REQ-023 tick held high continuously SHALL be treated as a tick every cycle; there is no edge detection on tick.

Reset
REQ-024 On clr_n=0, asynchronously: synchronizers=0, counters=0, up_db=down_db=0, state=IDLE, input_up=input_down=step=0.
REQ-025 Reset mid-debounce or mid-motion SHALL discard all progress.
REQ-026 After release, the first transition SHALL occur no earlier than 2 + DEBOUNCE_CYCLES cycles plus the next tick.

Structure
REQ-027 FSM state encoding (IDLE/UP/DOWN) and default DEBOUNCE_CYCLES SHALL live in the shared pong package used by gameplay.
REQ-028 One sub-module, btn_debounce (synchronizer + counter + state flop, parameterized by DEBOUNCE_CYCLES/CNT_W), SHALL be instantiated twice.
REQ-029 paddle_input SHALL be instantiated in the top level in place of the free-running test counter driving input_up/input_down.

Verification (DEBOUNCE_CYCLES=4, tick every 8 clk)
REQ-030 Reset: hold clr_n=0 with btn_up=1 -> all outputs 0; after release, up_db=1 exactly 6 clk later, and input_up=1 the clk after the next tick.
REQ-031 Bounce: btn_up toggles 1,0,1,0 with 2-cycle periods, then held at 1 -> up_db rises only 6 clk after the final rising edge; no glitch on input_up.
REQ-032 Glitch: btn_down pulsed high for 3 clk -> down_db, input_down and step stay 0 throughout.
REQ-033 Both pressed: from UP, assert btn_down -> on the first tick after down_db=1, state is IDLE and both outputs are 0; releasing btn_up then gives DOWN on the next tick after up_db falls.
REQ-034 Step count: hold btn_up for 5 ticks after entering UP -> exactly 5 single-cycle step pulses, input_up continuously 1.
REQ-035 Async reset mid-motion: pull clr_n low between clk edges while in DOWN -> input_down drops without waiting for a clk edge; the counter reads 0 after release.
